// File: rtl/pcie_wr_convert.sv
// pcie_wr_convert: steers a raster pixel stream into four quadrant DMA write ports,
// tracking frame position from pix_sof and flagging mid-frame SOF as a sync error.
module pcie_wr_convert #(
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int DW    = 32
) (
  input  logic          pclk_div2,
  input  logic          sys_rst_n,
  input  logic          pix_valid,
  input  logic          pix_sof,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  input  logic [3:0]    buf_full,
  output logic          dma_wr_A_wren,
  output logic          dma_wr_B_wren,
  output logic          dma_wr_C_wren,
  output logic          dma_wr_D_wren,
  output logic [DW-1:0] dma_wr_data,
  output logic          frame_done,
  output logic          sync_err,
  input  logic          err_clr
);
  typedef enum logic {WAIT_SOF, ACTIVE} state_t;
  localparam logic [11:0] H_LAST = 12'(H_ACT - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACT - 1);
  localparam logic [11:0] H_HALF = 12'(H_ACT / 2);
  localparam logic [11:0] V_HALF = 12'(V_ACT / 2);

  state_t        state_q, state_d;
  logic [11:0]   h_q, h_d, v_q, v_d;
  logic [3:0]    wren_q, wren_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d, err_q, err_d;
  logic [1:0]    quad, qsel;
  logic          wr, h_wrap, last;

  assign quad      = {v_q >= V_HALF, h_q >= H_HALF};
  assign pix_ready = (state_q == WAIT_SOF) | ~buf_full[quad];

  always_comb begin
    wr      = pix_valid & pix_ready & (pix_sof | (state_q == ACTIVE));
    qsel    = pix_sof ? 2'd0 : quad;
    h_wrap  = h_q == H_LAST;
    last    = h_wrap & (v_q == V_LAST);
    wren_d  = wr ? 4'b0001 << qsel : 4'b0000;
    data_d  = wr ? pix_data : data_q;
    done_d  = wr & ~pix_sof & last;
    err_d   = (wr & pix_sof & (state_q == ACTIVE) & ((h_q != 12'd0) | (v_q != 12'd0))) | (err_q & ~err_clr);
    state_d = !wr ? state_q : pix_sof ? ACTIVE : last ? WAIT_SOF : state_q;
    h_d     = !wr ? h_q : pix_sof ? 12'd1 : h_wrap ? 12'd0 : h_q + 12'd1;
    v_d     = !wr ? v_q : pix_sof ? 12'd0 : !h_wrap ? v_q : last ? 12'd0 : v_q + 12'd1;
  end

  always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= WAIT_SOF;
      h_q     <= '0;
      v_q     <= '0;
      wren_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign {dma_wr_D_wren, dma_wr_C_wren, dma_wr_B_wren, dma_wr_A_wren} = wren_q;
  assign dma_wr_data = data_q;
  assign frame_done  = done_q;
  assign sync_err    = err_q;
endmodule
